// File: rtl/alu_rr_arbiter_pkg.sv
// alu_rr_arbiter_pkg: ALU opcode encodings, data widths and opcode legality helper
package alu_rr_arbiter_pkg;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_DATA_W = 32;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b0111;

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_SLT, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR};
    endfunction
endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting after the last granted index
// Ports: req (request vector), last (previous winner), grant (one-hot),
//        idx (binary winner), any (some request present)
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);
    int j;

    // Scan in reverse priority order so the highest-priority hit is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = N; i >= 1; i--) begin
            j = (int'(last) + i) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = W'(j);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one combinational ALU with a one-entry tagged response register
// Ports: req_valid/req_ready/req_op/req_a/req_b (packed per-requester requests),
//        alu_op/alu_a/alu_b/alu_result/alu_zero (external ALU),
//        rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero/rsp_err (response).
// Optional: define ALU_RR_ARBITER_OPCHECK_EN to flag illegal opcodes via rsp_err.
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [ALU_OP_W*NUM_REQ-1:0]   req_op,
    input  logic [ALU_DATA_W*NUM_REQ-1:0] req_a,
    input  logic [ALU_DATA_W*NUM_REQ-1:0] req_b,
    output logic [ALU_OP_W-1:0]           alu_op,
    output logic [ALU_DATA_W-1:0]         alu_a,
    output logic [ALU_DATA_W-1:0]         alu_b,
    input  logic [ALU_DATA_W-1:0]         alu_result,
    input  logic                          alu_zero,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [ALU_DATA_W-1:0]         rsp_result,
    output logic                          rsp_zero,
    output logic                          rsp_err
);
    logic [ALU_OP_W-1:0]   op_arr [NUM_REQ];
    logic [ALU_DATA_W-1:0] a_arr  [NUM_REQ];
    logic [ALU_DATA_W-1:0] b_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       idx, mux_sel;
    logic                  any, slot_free, accept;
    logic [ID_W-1:0]       sel_q, sel_d, last_q, last_d, rsp_id_q, rsp_id_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d;
    logic [ALU_DATA_W-1:0] rsp_result_q, rsp_result_d;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign op_arr[g] = req_op[ALU_OP_W*g +: ALU_OP_W];
            assign a_arr[g]  = req_a[ALU_DATA_W*g +: ALU_DATA_W];
            assign b_arr[g]  = req_b[ALU_DATA_W*g +: ALU_DATA_W];
        end
    endgenerate

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    // rst_n gates ready so nothing handshakes while reset is held.
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign req_ready = grant & {NUM_REQ{slot_free && rst_n}};
    assign accept    = |(req_valid & req_ready);
    // Idle cycles reuse the previous select so the ALU inputs stay quiet.
    assign mux_sel   = any ? idx : sel_q;
    assign alu_op    = op_arr[mux_sel];
    assign alu_a     = a_arr[mux_sel];
    assign alu_b     = b_arr[mux_sel];

`ifdef ALU_RR_ARBITER_OPCHECK_EN
    logic rsp_err_q, rsp_err_d;
    logic op_bad;
    assign op_bad = !alu_op_legal(alu_op);
`endif

    always_comb begin
        sel_d        = mux_sel;
        last_d       = accept ? idx : last_q;
        rsp_valid_d  = accept ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_id_d     = accept ? idx : rsp_id_q;
        rsp_result_d = accept ? alu_result : rsp_result_q;
        rsp_zero_d   = accept ? alu_zero : rsp_zero_q;
`ifdef ALU_RR_ARBITER_OPCHECK_EN
        rsp_err_d    = accept ? op_bad : rsp_err_q;
        rsp_result_d = (accept && op_bad) ? '0 : rsp_result_d;
        rsp_zero_d   = (accept && op_bad) ? 1'b1 : rsp_zero_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            last_q       <= last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

`ifdef ALU_RR_ARBITER_OPCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_err_q <= 1'b0;
        else        rsp_err_q <= rsp_err_d;
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed self-checking bench with a behavioural ALU attached
module tb_alu_rr_arbiter;
    localparam int N = 4;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [4*N-1:0]  req_op;
    logic [32*N-1:0] req_a, req_b;
    logic [3:0]      alu_op;
    logic [31:0]     alu_a, alu_b, alu_result;
    logic            alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_err;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_result;
    int checks = 0, errors = 0;

    alu_rr_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU; unknown opcodes yield a marker value.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            4'b1010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0110: alu_result = alu_a ^ alu_b;
            4'b0111: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[4*i +: 4]   = op;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    initial begin
        logic [1:0] exp_id  [5];
        logic [31:0] exp_res [5];
        exp_id  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_res = '{32'd2, 32'd0, 32'h0F, 32'd12, 32'd2};
        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        set_req(0, 4'b0000, 32'd5, 32'd7);
        req_valid = 4'b0001;
        #2;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        #1;
        check("single_ready", 32'(req_ready), 32'b0001);
        check("single_alu_a", alu_a, 32'd5);
        tick();
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_result", rsp_result, 32'd12);
        check("single_zero", 32'(rsp_zero), 32'd0);

        set_req(1, 4'b0000, 32'd1, 32'd1);
        set_req(2, 4'b0010, 32'd3, 32'd3);
        set_req(3, 4'b0110, 32'hF0, 32'hFF);
        req_valid = 4'b1111;
        #1;
        check("fair_ready", 32'(req_ready), 32'b0010);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("fair_id%0d", i), 32'(rsp_id), 32'(exp_id[i]));
            check($sformatf("fair_res%0d", i), rsp_result, exp_res[i]);
            if (i == 1) check("fair_sub_zero", 32'(rsp_zero), 32'd1);
        end

        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_req(1, 4'b1010, 32'hFFFF_FFFF, 32'd1);
        #1;
        check("bp_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_res%0d", i), rsp_result, 32'd2);
            check($sformatf("bp_rdy%0d", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0010);
        tick();
        check("slt_valid", 32'(rsp_valid), 32'd1);
        check("slt_id", 32'(rsp_id), 32'd1);
        check("slt_result", rsp_result, 32'd1);

        set_req(1, 4'b0111, 32'd0, 32'd0);
        tick();
        check("nor_result", rsp_result, 32'hFFFF_FFFF);
        check("nor_zero", 32'(rsp_zero), 32'd0);
        req_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(rsp_valid), 32'd0);
        check("drain_id_hold", 32'(rsp_id), 32'd1);
        check("drain_res_hold", rsp_result, 32'hFFFF_FFFF);
        check("idle_alu_op_hold", 32'(alu_op), 32'b0111);

        set_req(1, 4'b0000, 32'd1, 32'd1);
        req_valid = 4'b0010; rsp_ready = 1'b0;
        tick();
        tick();
        check("stall_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_result", rsp_result, 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        set_req(0, 4'b0000, 32'd5, 32'd7);
        req_valid = 4'b1001;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        check("post_rst_id", 32'(rsp_id), 32'd0);
        check("post_rst_res", rsp_result, 32'd12);
        check("post_rst_next", 32'(req_ready), 32'b1000);
        tick();
        check("post_rst_id3", 32'(rsp_id), 32'd3);
        check("post_rst_res3", rsp_result, 32'h0F);

        set_req(0, 4'b0001, 32'd5, 32'd7);
        req_valid = 4'b0001;
        tick();
        check("bad_valid", 32'(rsp_valid), 32'd1);
`ifdef ALU_RR_ARBITER_OPCHECK_EN
        check("bad_err", 32'(rsp_err), 32'd1);
        check("bad_result", rsp_result, 32'd0);
        check("bad_zero", 32'(rsp_zero), 32'd1);
`else
        check("bad_err", 32'(rsp_err), 32'd0);
        check("bad_result", rsp_result, 32'hDEAD_BEEF);
`endif
        req_valid = 4'b1001;
        #1;
        check("bad_ptr_adv", 32'(req_ready), 32'b1000);
        tick();
        check("good_err", 32'(rsp_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
